// File: rtl/ts_form_if.sv
// ts_form_if: byte-in / 33-bit-word-out bundle of the TS record formatter.
//   master : the byte source and consumer of the records (testbench / upstream)
//   slave  : the formatter itself
// Signals:
//   din_8bit[7:0], din_8bit_en         TS byte stream
//   dst_mac[47:0], dst_ip[31:0],
//   dst_port[15:0]                     destination, sampled with the sync byte
//   dout_33bit[32:0], dout_33bit_en    record word, [32] marks the first word
//   pkt_done                           pulse alongside the last record word
//   sync_err, timeout_err              error pulses
interface ts_form_if;
    logic [7:0]  din_8bit;
    logic        din_8bit_en;
    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
    logic [32:0] dout_33bit;
    logic        dout_33bit_en;
    logic        pkt_done;
    logic        sync_err;
    logic        timeout_err;

    modport master (
        output din_8bit, din_8bit_en, dst_mac, dst_ip, dst_port,
        input  dout_33bit, dout_33bit_en, pkt_done, sync_err, timeout_err
    );

    modport slave (
        input  din_8bit, din_8bit_en, dst_mac, dst_ip, dst_port,
        output dout_33bit, dout_33bit_en, pkt_done, sync_err, timeout_err
    );
endinterface

// File: rtl/ts_form_8_32.sv
// ts_form_8_32: packs 188-byte MPEG-TS packets into 51-word, 33-bit records
// (4 header words carrying MAC/IP/port, then 47 payload words).
// Ports:
//   clk  system clock
//   rst  asynchronous, active-low reset
//   bus  ts_form_if.slave (byte input, destination fields, record output,
//        pkt_done / sync_err / timeout_err pulses)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | hunting for the sync byte; other bytes dropped with sync_err
// COLLECT | packing packet bytes, watching the inter-byte gap
// PAD     | packet timed out; fill bytes injected one per cycle
// GAP     | one-cycle separator after the last byte of a packet
module ts_form_8_32 #(
    parameter int          TS_LEN    = 188,
    parameter logic [7:0]  SYNC_BYTE = 8'h47,
    parameter int          GAP_MAX   = 64,
    parameter logic [7:0]  PAD_BYTE  = 8'hFF
) (
    input  logic      clk,
    input  logic      rst,
    ts_form_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, PAD, GAP} state_t;

    localparam logic [7:0] LAST_BYTE = 8'(TS_LEN - 1);
    localparam logic [6:0] GAP_LAST  = 7'(GAP_MAX - 1);
    localparam logic [6:0] GAP_SAT   = 7'(GAP_MAX);

    state_t      state, state_nxt;
    logic [7:0]  byte_cnt;
    logic [6:0]  gap_cnt;
    logic        take;
    logic        start;
    logic [7:0]  byte_val;
    logic        serr_nxt;
    logic        tout_nxt;

    logic [31:0] word_sr;
    logic        word_vld;
    logic        word_last;
    logic [15:0] mac_lo;
    logic [31:0] ip_q;
    logic [15:0] port_q;
    logic        hdr_busy;
    logic [1:0]  hdr_idx;

    logic [32:0] dout_q;
    logic        dout_en_q;
    logic        done_q;
    logic        serr_q;
    logic        tout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        start     = 1'b0;
        byte_val  = bus.din_8bit;
        serr_nxt  = 1'b0;
        tout_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.din_8bit_en) begin
                    if (bus.din_8bit == SYNC_BYTE) begin
                        start     = 1'b1;
                        take      = 1'b1;
                        state_nxt = COLLECT;
                    end else begin
                        serr_nxt = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (bus.din_8bit_en) begin
                    take = 1'b1;
                    if (byte_cnt == LAST_BYTE) state_nxt = GAP;
                end else if (gap_cnt == GAP_LAST) begin
                    tout_nxt  = 1'b1;
                    state_nxt = PAD;
                end
            end
            PAD: begin
                // external bytes are ignored while the packet is padded out
                take     = 1'b1;
                byte_val = PAD_BYTE;
                if (byte_cnt == LAST_BYTE) state_nxt = GAP;
            end
            GAP: begin
                state_nxt = IDLE;
                if (bus.din_8bit_en) serr_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // byte packing and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt  <= '0;
            gap_cnt   <= '0;
            word_sr   <= '0;
            word_vld  <= 1'b0;
            word_last <= 1'b0;
        end else begin
            if (start)              byte_cnt <= 8'd1;
            else if (take)          byte_cnt <= byte_cnt + 8'd1;
            else if (state == GAP)  byte_cnt <= '0;

            if (take || state != COLLECT) gap_cnt <= '0;
            else if (gap_cnt != GAP_SAT)  gap_cnt <= gap_cnt + 7'd1;

            word_vld  <= 1'b0;
            word_last <= 1'b0;
            if (take) begin
                // byte_cnt is 0 in IDLE, so the sync byte lands in lane 0
                word_sr   <= {word_sr[23:0], byte_val};
                word_vld  <= (byte_cnt[1:0] == 2'd3);
                word_last <= (byte_cnt == LAST_BYTE);
            end
        end
    end

    // output stage: header words straight after sync, payload one cycle
    // after packing; the header always finishes before the first payload
    // word can be ready, so the two never compete for the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_lo    <= '0;
            ip_q      <= '0;
            port_q    <= '0;
            hdr_busy  <= 1'b0;
            hdr_idx   <= '0;
            dout_q    <= '0;
            dout_en_q <= 1'b0;
            done_q    <= 1'b0;
            serr_q    <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            dout_en_q <= 1'b0;
            done_q    <= 1'b0;
            serr_q    <= serr_nxt;
            tout_q    <= tout_nxt;
            if (start) begin
                mac_lo    <= bus.dst_mac[15:0];
                ip_q      <= bus.dst_ip;
                port_q    <= bus.dst_port;
                dout_q    <= {1'b1, bus.dst_mac[47:16]};
                dout_en_q <= 1'b1;
                hdr_busy  <= 1'b1;
                hdr_idx   <= 2'd1;
            end else if (hdr_busy) begin
                dout_en_q <= 1'b1;
                case (hdr_idx)
                    2'd1: begin
                        dout_q  <= {1'b0, 16'h0, mac_lo};
                        hdr_idx <= 2'd2;
                    end
                    2'd2: begin
                        dout_q  <= {1'b0, ip_q};
                        hdr_idx <= 2'd3;
                    end
                    default: begin
                        dout_q   <= {1'b0, 16'h0, port_q};
                        hdr_idx  <= 2'd0;
                        hdr_busy <= 1'b0;
                    end
                endcase
            end else if (word_vld) begin
                dout_q    <= {1'b0, word_sr};
                dout_en_q <= 1'b1;
                done_q    <= word_last;
            end
        end
    end

    assign bus.dout_33bit    = dout_q;
    assign bus.dout_33bit_en = dout_en_q;
    assign bus.pkt_done      = done_q;
    assign bus.sync_err      = serr_q;
    assign bus.timeout_err   = tout_q;

endmodule

// File: tb/tb_ts_form_8_32.sv
module tb_ts_form_8_32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    ts_form_if bus();

    ts_form_8_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // monitor
    logic [32:0] mon_word[$];
    int          mon_cyc[$];
    bit          mon_done[$];
    int          n_serr = 0;
    int          n_tout = 0;
    int          tout_cyc = 0;
    int          n_stray = 0;

    always @(negedge clk) begin
        if (bus.dout_33bit_en) begin
            mon_word.push_back(bus.dout_33bit);
            mon_cyc.push_back(cyc);
            mon_done.push_back(bus.pkt_done);
        end else if (bus.pkt_done) begin
            n_stray++;
        end
        if (bus.sync_err) n_serr++;
        if (bus.timeout_err) begin
            n_tout++;
            tout_cyc = cyc;
        end
    end

    // expected records
    logic [32:0] exp_word[$];
    int          exp_cyc[$];
    bit          exp_done[$];

    logic [7:0] pkt[188];
    int         acc[188];

    task automatic drive(input bit en, input logic [7:0] b);
        @(negedge clk);
        bus.din_8bit_en = en;
        bus.din_8bit    = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic send_pkt(input int nbytes, input bit rnd, input bit chg);
        for (int i = 0; i < nbytes; i++) begin
            if (rnd && i > 0) idle(int'($urandom_range(1, 3)));
            drive(1'b1, pkt[i]);
            acc[i] = cyc;
            if (chg && i == 10) begin
                bus.dst_mac  = 48'hDEAD_BEEF_CAFE;
                bus.dst_ip   = 32'h0A0B_0C0D;
                bus.dst_port = 16'h1234;
            end
        end
    endtask

    task automatic push_exp(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] port);
        int t;
        t = acc[0];
        exp_word.push_back({1'b1, mac[47:16]});          exp_cyc.push_back(t + 1); exp_done.push_back(1'b0);
        exp_word.push_back({1'b0, 16'h0, mac[15:0]});    exp_cyc.push_back(t + 2); exp_done.push_back(1'b0);
        exp_word.push_back({1'b0, ip});                  exp_cyc.push_back(t + 3); exp_done.push_back(1'b0);
        exp_word.push_back({1'b0, 16'h0, port});         exp_cyc.push_back(t + 4); exp_done.push_back(1'b0);
        for (int k = 0; k < 47; k++) begin
            exp_word.push_back({1'b0, pkt[4*k], pkt[4*k+1], pkt[4*k+2], pkt[4*k+3]});
            exp_cyc.push_back(acc[4*k+3] + 2);
            exp_done.push_back(k == 46);
        end
    endtask

    task automatic check_records(input string tag);
        int n;
        chk({tag, " words"}, 64'(mon_word.size()), 64'(exp_word.size()));
        n = (mon_word.size() < exp_word.size()) ? mon_word.size() : exp_word.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s w%0d data", tag, i), 64'(mon_word[i]), 64'(exp_word[i]));
            chk($sformatf("%s w%0d cycle", tag, i), 64'(mon_cyc[i]), 64'(exp_cyc[i]));
            chk($sformatf("%s w%0d done", tag, i), 64'(mon_done[i]), 64'(exp_done[i]));
        end
        mon_word.delete(); mon_cyc.delete(); mon_done.delete();
        exp_word.delete(); exp_cyc.delete(); exp_done.delete();
    endtask

    task automatic set_dst(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] port);
        bus.dst_mac  = mac;
        bus.dst_ip   = ip;
        bus.dst_port = port;
    endtask

    task automatic fill_pkt(input logic [7:0] seed);
        pkt[0] = 8'h47;
        for (int i = 1; i < 188; i++) pkt[i] = 8'(i - 1) + seed;
    endtask

    initial begin
        int s0, t0, c;
        bus.din_8bit    = '0;
        bus.din_8bit_en = 1'b0;
        set_dst(48'h0011_2233_4455, 32'hC0A8_0001, 16'h1F90);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst dout", 64'(bus.dout_33bit), 64'h0);
        chk("rst en", 64'(bus.dout_33bit_en), 64'h0);
        chk("rst done", 64'(bus.pkt_done), 64'h0);
        chk("rst serr", 64'(bus.sync_err), 64'h0);
        chk("rst tout", 64'(bus.timeout_err), 64'h0);
        rst = 1'b1;
        idle(3);

        // 1: contiguous packet
        fill_pkt(8'h00);
        send_pkt(188, 1'b0, 1'b0);
        push_exp(48'h0011_2233_4455, 32'hC0A8_0001, 16'h1F90);
        idle(6);
        chk("t1 w0 const", 64'(mon_word[0]), 64'h1_0011_2233);
        chk("t1 w1 const", 64'(mon_word[1]), 64'h0_0000_4455);
        chk("t1 w2 const", 64'(mon_word[2]), 64'h0_C0A8_0001);
        chk("t1 w3 const", 64'(mon_word[3]), 64'h0_0000_1F90);
        chk("t1 w4 const", 64'(mon_word[4]), 64'h0_4700_0102);
        chk("t1 w4 at T+5", 64'(mon_cyc[4] - acc[0]), 64'd5);
        check_records("t1");

        // 2: junk before sync
        s0 = n_serr;
        drive(1'b1, 8'h12); drive(1'b1, 8'h34); drive(1'b1, 8'h56);
        idle(1);
        fill_pkt(8'h20);
        send_pkt(188, 1'b0, 1'b0);
        push_exp(48'h0011_2233_4455, 32'hC0A8_0001, 16'h1F90);
        idle(6);
        chk("t2 sync_err", 64'(n_serr - s0), 64'd3);
        check_records("t2");

        // 3: stall after byte 100 -> padded; bytes during PAD dropped silently
        s0 = n_serr;
        t0 = n_tout;
        set_dst(48'hA1A2_A3A4_A5A6, 32'h0102_0304, 16'h0050);
        pkt[0] = 8'h47;
        for (int i = 1; i < 100; i++) pkt[i] = 8'(i * 3);
        for (int i = 100; i < 188; i++) pkt[i] = 8'hFF;
        send_pkt(100, 1'b0, 1'b0);
        c = acc[99];
        for (int i = 100; i < 188; i++) acc[i] = c + 65 + (i - 100);
        idle(64);
        repeat (5) drive(1'b1, 8'h47);
        idle(100);
        push_exp(48'hA1A2_A3A4_A5A6, 32'h0102_0304, 16'h0050);
        chk("t3 timeout count", 64'(n_tout - t0), 64'd1);
        chk("t3 timeout cycle", 64'(tout_cyc), 64'(c + 65));
        chk("t3 no sync_err", 64'(n_serr - s0), 64'd0);
        chk("t3 w50 const", 64'(mon_word[50]), 64'h0_FFFF_FFFF);
        check_records("t3");

        // 4: random gaps, destination changed mid-packet
        set_dst(48'h0102_0304_0506, 32'hFFEE_DDCC, 16'hBEEF);
        fill_pkt(8'h55);
        pkt[40] = 8'h47;
        send_pkt(188, 1'b1, 1'b1);
        push_exp(48'h0102_0304_0506, 32'hFFEE_DDCC, 16'hBEEF);
        idle(6);
        check_records("t4");

        // 5: sync in GAP cycle dropped, sync one cycle later accepted
        s0 = n_serr;
        set_dst(48'h1111_2222_3333, 32'h4444_5555, 16'h6666);
        fill_pkt(8'h80);
        send_pkt(188, 1'b0, 1'b0);
        push_exp(48'h1111_2222_3333, 32'h4444_5555, 16'h6666);
        drive(1'b1, 8'h47);
        fill_pkt(8'h90);
        send_pkt(188, 1'b0, 1'b0);
        push_exp(48'h1111_2222_3333, 32'h4444_5555, 16'h6666);
        idle(6);
        chk("t5 sync_err", 64'(n_serr - s0), 64'd1);
        check_records("t5");

        // 6: reset at word 20, then a clean record
        set_dst(48'h7777_8888_9999, 32'hAAAA_BBBB, 16'hCCCC);
        fill_pkt(8'h10);
        send_pkt(68, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6 rst dout", 64'(bus.dout_33bit), 64'h0);
        chk("t6 rst en", 64'(bus.dout_33bit_en), 64'h0);
        chk("t6 rst done", 64'(bus.pkt_done), 64'h0);
        push_exp(48'h7777_8888_9999, 32'hAAAA_BBBB, 16'hCCCC);
        repeat (30) begin
            void'(exp_word.pop_back()); void'(exp_cyc.pop_back()); void'(exp_done.pop_back());
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(20);
        check_records("t6 abandoned");
        fill_pkt(8'h33);
        send_pkt(188, 1'b0, 1'b0);
        push_exp(48'h7777_8888_9999, 32'hAAAA_BBBB, 16'hCCCC);
        idle(6);
        check_records("t6 clean");

        chk("stray pkt_done", 64'(n_stray), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ts_form_8_32.md
Name: ts_form_8_32

Overview:
- Upstream feeder of the 33-bit-to-byte transmit formatter.
- Accepts a byte stream of 188-byte MPEG-TS packets and the current destination MAC/IP/port.
- Emits one 51-word record per packet on a 33-bit word interface: 4 header words, then 47 payload words.
- Bit 32 flags the first word of each record. Output is write-only; the downstream FIFO absorbs it and there is no backpressure.

Parameters:
- TS_LEN, 188, bytes per TS packet (multiple of 4).
- SYNC_BYTE, 8'h47, required value of the first packet byte.
- GAP_MAX, 64, maximum idle cycles between bytes inside a packet before timeout.
- PAD_BYTE, 8'hFF, fill byte used to complete a timed-out packet.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- din_8bit  input  8  TS byte
- din_8bit_en  input  1  din_8bit valid this cycle
- dst_mac  input  48  destination MAC, sampled on the sync byte
- dst_ip  input  32  destination IP, sampled on the sync byte
- dst_port  input  16  destination UDP port, sampled on the sync byte
- dout_33bit  output  33  record word; [32] = first-word flag
- dout_33bit_en  output  1  dout_33bit valid, one word per cycle max
- pkt_done  output  1  one-cycle pulse with the last word of a record
- sync_err  output  1  one-cycle pulse per dropped byte
- timeout_err  output  1  one-cycle pulse on entering PAD

Behaviour:
- Reset: rst low asynchronously clears every output to 0, the state to IDLE, and all counters and latches. This holds mid-record too: a partial record is abandoned and nothing further is emitted for it.
- Record format (T = cycle the sync byte is accepted):
  - w0 = {1, mac[47:16]}
  - w1 = {0, 16'h0, mac[15:0]}
  - w2 = {0, ip}
  - w3 = {0, 16'h0, port}
  - w4..w50 = {0, b[4k], b[4k+1], b[4k+2], b[4k+3]}, first byte in [31:24].
- Header timing: w0..w3 are driven on T+1, T+2, T+3, T+4 (dout_33bit_en high each cycle), using the dst_* values latched at T.
- Payload timing: payload word k is driven exactly 2 cycles after the cycle its 4th byte is accepted. With contiguous input, word 0 lands at T+5 and never collides with a header word.
- pkt_done is high with w50. dout_33bit holds its last value when en is low.
- FSM states:
  - IDLE: byte == SYNC_BYTE -> COLLECT (byte_cnt=1, latch dst_*). Any other byte is dropped with a sync_err pulse.
  - COLLECT: each en byte is packed and byte_cnt increments. A gap counter clears on each byte and increments on each idle cycle. byte_cnt reaching TS_LEN -> GAP. Gap counter reaching GAP_MAX -> PAD with a timeout_err pulse.
  - PAD: injects PAD_BYTE once per cycle as if received; din bytes are dropped silently. byte_cnt reaching TS_LEN -> GAP.
  - GAP: exactly one cycle, then IDLE. Any byte arriving here is dropped with a sync_err pulse. Upstream guarantees at least one idle cycle between packets.
- Boundaries:
  - A 0x47 byte inside COLLECT is payload, not a resync.
  - A timeout during header emission still completes the header; pads start immediately and payload word timing follows the same 2-cycle rule.
  - A record is always exactly 51 words, so downstream framing never slips.
  - Counters: byte_cnt 8 bits, gap counter 7 bits with saturation at GAP_MAX.

Test Plan:
- One contiguous packet (0x47, 0x00..0xBA), mac=0x0011_2233_4455, ip=0xC0A8_0001, port=0x1F90:
  - w0=0x1_0011_2233, w1=0x0_0000_4455, w2=0x0_C0A8_0001, w3=0x0_0000_1F90 on T+1..T+4.
  - w4=0x0_4700_0102 at T+5; 51 words total; pkt_done with w50.
- Three bytes 0x12, 0x34, 0x56, then a sync packet -> three sync_err pulses, then exactly one well-formed record.
- Packet stalls after byte 100 for GAP_MAX cycles -> one timeout_err pulse. Bytes 100..187 = 0xFF; w50=0x0_FFFF_FFFF; still 51 words.
- dst_* changed mid-packet and packet bytes with random 1-3 cycle gaps -> header uses values at T. Each payload word appears exactly 2 cycles after its 4th byte; en is never high on two words at once.
- Sync byte in the cycle right after byte 188 -> sync_err, no record. A sync one cycle later -> record accepted; its w0 is not overlapped by the prior record's w50.
- rst pulsed low at word 20 -> outputs 0 immediately, no further words. The next packet produces a clean 51-word record.
